// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment decode for the seven-segment scanner
package seg7_pkg;

  // All segments dark (active-low outputs)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns, bit 6 = A ... bit 0 = G
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    return HEX_SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low segment decoder
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; kept as a module so the top has a single decode point
  always_comb begin
    seg_o = hex2seg(hex_i);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed N-digit seven-segment scan controller
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   en_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(REFRESH_DIV - 1);
  localparam logic [PS_W-1:0]  BLANK_END = PS_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_ctrl: N_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("seg7_scan_ctrl: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_CYCLES must be < REFRESH_DIV");
  end

  logic [PS_W-1:0]       prescaler_q, prescaler_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [4*N_DIGITS-1:0] hex_pend_q, hex_pend_d, hex_act_q, hex_act_d;
  logic [N_DIGITS-1:0]   dp_pend_q, dp_pend_d, dp_act_q, dp_act_d;
  logic [N_DIGITS-1:0]   en_pend_q, en_pend_d, en_act_q, en_act_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_start_q;

  logic                  tick, wrap;
  logic [3:0]            sel_hex;
  logic                  sel_dp, sel_en, an_on;
  logic [6:0]            dec_seg;

  assign tick = (prescaler_q == PS_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  // Slot timing: prescaler divides down to digit slots, idx walks the digits
  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double-buffered digit data: active bank only changes at a frame wrap
  always_comb begin
    pending_d  = pending_q;
    hex_pend_d = hex_pend_q;
    dp_pend_d  = dp_pend_q;
    en_pend_d  = en_pend_q;
    hex_act_d  = hex_act_q;
    dp_act_d   = dp_act_q;
    en_act_d   = en_act_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        // Load landing on the commit edge goes straight to the display
        hex_act_d = hex_in;
        dp_act_d  = dp_in;
        en_act_d  = en_in;
      end else if (pending_q) begin
        hex_act_d = hex_pend_q;
        dp_act_d  = dp_pend_q;
        en_act_d  = en_pend_q;
      end
    end else if (load) begin
      pending_d  = 1'b1;
      hex_pend_d = hex_in;
      dp_pend_d  = dp_in;
      en_pend_d  = en_in;
    end
  end

  // Select the current digit's nibble, point and enable, and build the anode vector
  always_comb begin
    sel_hex = '0;
    sel_dp  = 1'b0;
    sel_en  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_hex = hex_act_q[4*k +: 4];
        sel_dp  = dp_act_q[k];
        sel_en  = en_act_q[k];
      end
    end
    an_on = (prescaler_q >= BLANK_END) && sel_en;
    an_d  = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (an_on && (idx_q == IDX_W'(k))) begin
        an_d[k] = 1'b0;
      end
    end
    seg_d = an_on ? dec_seg : SEG_OFF;
    dp_d  = an_on ? ~sel_dp : 1'b1;
  end

  seg7_hex_decode u_hex_decode (
    .hex_i (sel_hex),
    .seg_o (dec_seg)
  );

  // State and registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q   <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      hex_pend_q    <= '0;
      dp_pend_q     <= '0;
      en_pend_q     <= '0;
      hex_act_q     <= '0;
      dp_act_q      <= '0;
      en_act_q      <= '0;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      hex_pend_q    <= hex_pend_d;
      dp_pend_q     <= dp_pend_d;
      en_pend_q     <= en_pend_d;
      hex_act_q     <= hex_act_d;
      dp_act_q      <= dp_act_d;
      en_act_q      <= en_act_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= wrap;
    end
  end

  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign an_n        = an_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule
